// File: rtl/seq_left_shifter_if.sv
// Handshake and data bundle between the ALU issue logic (master) and the
// multi-cycle left shift/rotate unit (slave).
interface seq_left_shifter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] In;
    logic [CNT_W-1:0] Cnt;
    logic             Rot;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Out;

    modport master (
        output start, In, Cnt, Rot,
        input  busy, done, Out
    );

    modport slave (
        input  start, In, Cnt, Rot,
        output busy, done, Out
    );
endinterface

// File: rtl/seq_left_shifter.sv
// Iterative left shift / rotate unit with start/busy/done handshake.
// Define FAST_SHIFT_EN to step by 4 bits while at least 4 remain.
module seq_left_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    seq_left_shifter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             rot_q, rot_d;

    // Out doubles as the working register, so intermediate values are visible while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            rem_q   <= '0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            rot_q   <= rot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
        rot_d   = rot_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    out_d   = bus.In;
                    rem_d   = bus.Cnt;
                    rot_d   = bus.Rot;
                    state_d = (bus.Cnt == '0) ? DONE : SHIFT;
                end
            end

            SHIFT: begin
`ifdef FAST_SHIFT_EN
                if (rem_q >= CNT_W'(4)) begin
                    out_d = rot_q ? {out_q[WIDTH-5:0], out_q[WIDTH-1:WIDTH-4]}
                                  : {out_q[WIDTH-5:0], 4'b0000};
                    rem_d = rem_q - CNT_W'(4);
                end else begin
                    out_d = {out_q[WIDTH-2:0], rot_q & out_q[WIDTH-1]};
                    rem_d = rem_q - CNT_W'(1);
                end
`else
                out_d = {out_q[WIDTH-2:0], rot_q & out_q[WIDTH-1]};
                rem_d = rem_q - CNT_W'(1);
`endif
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.Out  = out_q;

endmodule

// File: doc/seq_left_shifter.md
Name: seq_left_shifter

Overview:
- Multi-cycle left shift/rotate unit for the execute stage; the counterpart to the combinational logical right shifter.
- Accepts a 16-bit operand, a 4-bit count and an op select.
- Shifts or rotates left iteratively under a start/busy/done handshake.
- Holds the result until the next accepted start; the ALU uses it for SLL/ROL-class instructions.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CNT_W, 4, count width in bits; WIDTH = 2**CNT_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- In  input  WIDTH  operand; captured on accepted start.
- Cnt  input  CNT_W  shift amount 0..15; captured on accepted start.
- Rot  input  1  0 = logical left shift (zero fill), 1 = rotate left; captured on accepted start.
- busy  output  1  high in SHIFT state.
- done  output  1  one-cycle pulse when Out becomes valid.
- Out  output  WIDTH  result register.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, Out=0, internal remaining count=0.
- rst asserted mid-operation aborts at that edge. The same reset values apply and no done is emitted.
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, capture In into the working register (Out), Cnt into rem, and Rot into rot_q.
  - If Cnt=0, go to DONE.
  - Otherwise go to SHIFT.
  - start=0 holds IDLE; Out is unchanged.
- SHIFT: each cycle, step the working register and decrement rem by 1.
  - SLL step: {Out[WIDTH-2:0],1'b0}.
  - ROL step: {Out[WIDTH-2:0],Out[WIDTH-1]}.
  - When rem reaches 0 after the decrement (rem==1 before), go to DONE.
  - busy=1 throughout SHIFT.
- DONE: done=1 for exactly one cycle, busy=0. Next state is IDLE unconditionally.
- start is ignored in SHIFT and DONE. There is no queueing; the requester must wait for done.
- Latency in base build, from the start edge to the done cycle: Cnt+1 cycles.
  - Cnt=0 gives done on the cycle after start.
  - Cnt=15 gives done 16 cycles after start.
- Out is stable and valid from the done cycle until the next accepted start. It changes during SHIFT (intermediate values) and is not valid then.
- Inputs In/Cnt/Rot may change freely after the start cycle; only the captured values are used.
- Back-to-back: start asserted in the cycle after done (IDLE) is accepted. The minimum issue interval is Cnt+2 cycles.
- Final result equals In<<Cnt (zero fill) for SLL, or a rotate of In left by Cnt for ROL. Bits shifted past MSB are discarded for SLL.

Optional Feature:
- Macro: FAST_SHIFT_EN.
- When defined, SHIFT steps by 4 whenever rem>=4, else by 1.
  - 4-bit SLL step: {Out[WIDTH-5:0],4'b0}.
  - 4-bit ROL step: {Out[WIDTH-5:0],Out[WIDTH-1:WIDTH-4]}.
  - rem decrements by 4 or 1 to match.
  - Latency becomes floor(Cnt/4)+(Cnt mod 4)+1 cycles; Cnt=15 gives 7 cycles.
- When undefined, single-bit stepping as above.
- Results are identical in both builds; only latency differs.

Test Plan:
- Reset, then idle → busy=0, done=0, Out=16'h0000. Hold rst high for 3 cycles with start=1 → no busy, no done.
- start, In=16'h8001, Cnt=1, Rot=0 → busy for 1 cycle, done on 2nd cycle, Out=16'h0002. With Rot=1 → Out=16'h0003.
- In=16'hABCD, Cnt=4, Rot=1 → Out=16'hBCDA, done 5 cycles after start (FAST_SHIFT_EN: 2 cycles). With Rot=0 → Out=16'hBCD0.
- In=16'h1234, Cnt=0 → done next cycle, Out=16'h1234. Also In=16'hFFFF, Cnt=15, Rot=0 → Out=16'h8000 after 16 cycles (FAST_SHIFT_EN: 7).
- start pulsed again with In=16'h0F0F while busy → ignored; the original operation completes with the correct result. A new start the cycle after done is accepted.
- Start Cnt=10, assert rst at cycle 5 → no done pulse, Out=0, state IDLE. A subsequent start of In=16'h0001, Cnt=3, Rot=0 → Out=16'h0008.
